// File: rtl/bru_pkg.sv
// Shared definitions for the branch resolve unit: condition codes,
// alu_fetch_interface bit positions and the resolver FSM state type.
package bru_pkg;

  localparam logic [2:0] COND_EQ = 3'd0;
  localparam logic [2:0] COND_NE = 3'd1;
  localparam logic [2:0] COND_LT = 3'd2;
  localparam logic [2:0] COND_GE = 3'd3;
  localparam logic [2:0] COND_CS = 3'd4;
  localparam logic [2:0] COND_CC = 3'd5;
  localparam logic [2:0] COND_AL = 3'd6;
  localparam logic [2:0] COND_NV = 3'd7;

  localparam int AFI_MISPRED   = 0;
  localparam int AFI_BADDR_LSB = 1;
  localparam int AFI_REDIR_LSB = 9;
  localparam int AFI_ISCOND    = 17;
  localparam int AFI_TAKEN     = 18;
  localparam int AFI_W         = 19;

  typedef enum logic [1:0] {RUN, HOLD, SQUASH} bru_state_e;

endpackage

// File: rtl/bru_cond_eval.sv
// Combinational condition-code evaluation against ALU flags (0 cycles).
// No state and no backpressure; shared with predicated-move logic.
module bru_cond_eval
  import bru_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       flag_z,
  input  logic       flag_n,
  input  logic       flag_c,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    unique case (cond)
      COND_EQ: taken = flag_z;
      COND_NE: taken = ~flag_z;
      COND_LT: taken = flag_n;
      COND_GE: taken = ~flag_n;
      COND_CS: taken = flag_c;
      COND_CC: taken = ~flag_c;
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves conditional branches, 1-cycle registered feedback to fetch; mispredicts hold until pipe_advance,
// then SQUASH_CYCLES advancing cycles drop wrong-path branches. Optional BRU_STATS_EN adds saturating counters.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int ADDR_W        = 8,
  parameter int PC_STEP       = 2,
  parameter int SQUASH_CYCLES = 2
`ifdef BRU_STATS_EN
  ,
  parameter int CNT_W         = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
`ifdef BRU_STATS_EN
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  stat_branches,
  output logic [CNT_W-1:0]  stat_mispredicts,
`endif
  input  logic              ex_valid,
  input  logic              ex_is_cond,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              ex_pred_taken,
  input  logic [2:0]        ex_cond,
  input  logic              flag_z,
  input  logic              flag_n,
  input  logic              flag_c,
  input  logic              pipe_advance,
  output logic [AFI_W-1:0]  alu_fetch_interface,
  output logic              bru_busy
);

  localparam int SQ_W = $clog2(SQUASH_CYCLES + 2);

  bru_state_e        state_q, state_d;
  logic [SQ_W-1:0]   cnt_q, cnt_d;
  logic [AFI_W-1:0]  afi_q, afi_d;
  logic              taken;
  logic              accept;
  logic              mispred;
  logic [ADDR_W-1:0] redirect;

  bru_cond_eval u_cond_eval (
    .cond   (ex_cond),
    .flag_z (flag_z),
    .flag_n (flag_n),
    .flag_c (flag_c),
    .taken  (taken)
  );

  assign accept   = ex_valid & ex_is_cond & pipe_advance & (state_q == RUN);
  assign mispred  = taken != ex_pred_taken;
  assign redirect = taken ? ex_target : ex_pc + ADDR_W'(PC_STEP);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    afi_d   = afi_q;
    // Predictor-update strobe is a one-cycle pulse per accepted branch.
    afi_d[AFI_ISCOND] = 1'b0;
    afi_d[AFI_TAKEN]  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (accept) begin
          afi_d[AFI_MISPRED]               = mispred;
          afi_d[AFI_BADDR_LSB +: ADDR_W]   = ex_pc;
          afi_d[AFI_REDIR_LSB +: ADDR_W]   = redirect;
          afi_d[AFI_ISCOND]                = 1'b1;
          afi_d[AFI_TAKEN]                 = taken;
          if (mispred) state_d = HOLD;
        end
      end
      HOLD: begin
        if (pipe_advance) begin
          afi_d[AFI_MISPRED] = 1'b0;
          cnt_d              = SQ_W'(SQUASH_CYCLES);
          state_d            = (SQUASH_CYCLES == 0) ? RUN : SQUASH;
        end
      end
      SQUASH: begin
        if (pipe_advance) begin
          cnt_d = cnt_q - SQ_W'(1);
          if (cnt_q == SQ_W'(1)) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      afi_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      afi_q   <= afi_d;
    end
  end

  assign alu_fetch_interface = afi_q;
  assign bru_busy            = state_q != RUN;

`ifdef BRU_STATS_EN
  logic [CNT_W-1:0] stat_br_q, stat_br_d;
  logic [CNT_W-1:0] stat_mp_q, stat_mp_d;

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (stat_clr) begin
      stat_br_d = '0;
      stat_mp_d = '0;
    end else if (accept) begin
      if (~&stat_br_q)            stat_br_d = stat_br_q + CNT_W'(1);
      if (mispred && ~&stat_mp_q) stat_mp_d = stat_mp_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule
